hazard_stall_ctrl: RTL and testbench

Parametrised hazard detection and stall controller for the RV32i pipeline, sitting between decode (ID) and the IF/ID, ID/EX pipeline registers and PC. It generalises load-use and ID-resolved branch/JALR hazard detection to NUM_SRC source operands with per-operand "used" qualifiers. It adds a sequential hold engine for multicycle EX operations, redirect flushing of IF/ID, and an optional stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall control for the RV32i ID stage: load-use, ID-resolved branch/JALR, multicycle EX hold.
// Optional stall-cycle counter is built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_SRC        = 2,
  parameter int MULTICYCLE_LAT = 4,
  parameter int CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          EX_cntl_MemRead,
  input  logic                          EX_cntl_RegWrite,
  input  logic                          MEM_cntl_MemRead,
  input  logic [6:0]                    ID_opcode,
  input  logic                          ID_valid,
  input  logic                          ID_multicycle,
  input  logic                          ID_redirect,
  input  logic [REG_ADDR_W-1:0]         EX_WriteRegNum,
  input  logic [REG_ADDR_W-1:0]         MEM_WriteRegNum,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_ReadRegNum,
  input  logic [NUM_SRC-1:0]            ID_ReadRegUsed,
  output logic                          PCWrite,
  output logic                          IF_IDWrite,
  output logic                          ID_EXFlush,
  output logic                          IF_IDFlush,
  output logic                          EX_hold,
  output logic                          busy,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int CNT_BITS = $clog2(MULTICYCLE_LAT) + 1;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [NUM_SRC-1:0]  matchE, matchM, ctrlMask;
  logic                isBranch, isJalr, loadUse, ctrlHaz, dataStall, startHold;

  assign isBranch = (ID_opcode == OPC_BRANCH);
  assign isJalr   = (ID_opcode == OPC_JALR);

  // JALR reads only rs1; branches compare rs1 and rs2.
  always_comb begin
    matchE   = '0;
    matchM   = '0;
    ctrlMask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      matchE[i]   = ID_ReadRegUsed[i] &&
                    (ID_ReadRegNum[i*REG_ADDR_W +: REG_ADDR_W] == EX_WriteRegNum) &&
                    (ID_ReadRegNum[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      matchM[i]   = ID_ReadRegUsed[i] &&
                    (ID_ReadRegNum[i*REG_ADDR_W +: REG_ADDR_W] == MEM_WriteRegNum) &&
                    (ID_ReadRegNum[i*REG_ADDR_W +: REG_ADDR_W] != '0);
      ctrlMask[i] = (isBranch && (i < 2)) || (isJalr && (i == 0));
    end
  end

  assign loadUse   = ID_valid && EX_cntl_MemRead && (|matchE);
  assign ctrlHaz   = ID_valid && (isBranch || isJalr) &&
                     ((EX_cntl_RegWrite && (|(matchE & ctrlMask))) ||
                      (MEM_cntl_MemRead && (|(matchM & ctrlMask))));
  assign dataStall = loadUse || ctrlHaz;
  assign startHold = (MULTICYCLE_LAT > 1) && (state == IDLE) &&
                     ID_valid && ID_multicycle && !dataStall;

  // The issuing cycle itself runs normally, so the hold lasts MULTICYCLE_LAT-1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (startHold) begin
        state <= BUSY;
        cnt   <= CNT_BITS'(MULTICYCLE_LAT - 2);
      end
    end else begin
      if (cnt == '0) state <= IDLE;
      else           cnt   <= cnt - 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXFlush = 1'b0;
    IF_IDFlush = 1'b0;
    EX_hold    = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      if (state == BUSY) begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        EX_hold    = 1'b1;
        busy       = 1'b1;
      end else if (dataStall) begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        ID_EXFlush = 1'b1;
      end else if (ID_redirect) begin
        IF_IDFlush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk) begin
    if (reset)                          stallCnt <= '0;
    else if (!PCWrite && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance at MULTICYCLE_LAT=4, one at MULTICYCLE_LAT=1.
module tb_hazard_stall_ctrl;

  logic        clk, reset;
  logic        EX_cntl_MemRead, EX_cntl_RegWrite, MEM_cntl_MemRead;
  logic [6:0]  ID_opcode;
  logic        ID_valid, ID_multicycle, ID_redirect;
  logic [4:0]  EX_WriteRegNum, MEM_WriteRegNum;
  logic [9:0]  ID_ReadRegNum;
  logic [1:0]  ID_ReadRegUsed;
  logic        PCWrite, IF_IDWrite, ID_EXFlush, IF_IDFlush, EX_hold, busy;
  logic        PCWrite1, IF_IDWrite1, ID_EXFlush1, IF_IDFlush1, EX_hold1, busy1;
  logic [31:0] stall_cycles, stall_cycles1;
  logic [5:0]  outs, outs1;

  int checks = 0;
  int failures = 0;

  // {PCWrite, IF_IDWrite, ID_EXFlush, IF_IDFlush, EX_hold, busy}
  localparam logic [5:0] NORMAL   = 6'b110000;
  localparam logic [5:0] STALL    = 6'b001000;
  localparam logic [5:0] REDIRECT = 6'b110100;
  localparam logic [5:0] HOLD     = 6'b000011;

  assign outs  = {PCWrite, IF_IDWrite, ID_EXFlush, IF_IDFlush, EX_hold, busy};
  assign outs1 = {PCWrite1, IF_IDWrite1, ID_EXFlush1, IF_IDFlush1, EX_hold1, busy1};

  hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .MULTICYCLE_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .EX_cntl_MemRead(EX_cntl_MemRead), .EX_cntl_RegWrite(EX_cntl_RegWrite),
    .MEM_cntl_MemRead(MEM_cntl_MemRead), .ID_opcode(ID_opcode),
    .ID_valid(ID_valid), .ID_multicycle(ID_multicycle), .ID_redirect(ID_redirect),
    .EX_WriteRegNum(EX_WriteRegNum), .MEM_WriteRegNum(MEM_WriteRegNum),
    .ID_ReadRegNum(ID_ReadRegNum), .ID_ReadRegUsed(ID_ReadRegUsed),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EXFlush(ID_EXFlush),
    .IF_IDFlush(IF_IDFlush), .EX_hold(EX_hold), .busy(busy),
    .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .MULTICYCLE_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .EX_cntl_MemRead(EX_cntl_MemRead), .EX_cntl_RegWrite(EX_cntl_RegWrite),
    .MEM_cntl_MemRead(MEM_cntl_MemRead), .ID_opcode(ID_opcode),
    .ID_valid(ID_valid), .ID_multicycle(ID_multicycle), .ID_redirect(ID_redirect),
    .EX_WriteRegNum(EX_WriteRegNum), .MEM_WriteRegNum(MEM_WriteRegNum),
    .ID_ReadRegNum(ID_ReadRegNum), .ID_ReadRegUsed(ID_ReadRegUsed),
    .PCWrite(PCWrite1), .IF_IDWrite(IF_IDWrite1), .ID_EXFlush(ID_EXFlush1),
    .IF_IDFlush(IF_IDFlush1), .EX_hold(EX_hold1), .busy(busy1),
    .stall_cycles(stall_cycles1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    EX_cntl_MemRead  = 1'b0;
    EX_cntl_RegWrite = 1'b0;
    MEM_cntl_MemRead = 1'b0;
    ID_opcode        = 7'b0110011;
    ID_valid         = 1'b1;
    ID_multicycle    = 1'b0;
    ID_redirect      = 1'b0;
    EX_WriteRegNum   = 5'd0;
    MEM_WriteRegNum  = 5'd0;
    ID_ReadRegNum    = '0;
    ID_ReadRegUsed   = 2'b00;
  endtask

  task automatic setLoadUse();
    clearIn();
    EX_cntl_MemRead = 1'b1;
    EX_WriteRegNum  = 5'd1;
    ID_ReadRegNum   = {5'd1, 5'd0};
    ID_ReadRegUsed  = 2'b11;
  endtask

  initial begin
    reset = 1'b1;
    setLoadUse();
    ID_multicycle = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("reset_outs", 32'(outs), 32'(NORMAL));
    check("reset_cnt", stall_cycles, 32'd0);

    @(negedge clk); reset = 1'b0; clearIn(); #1;
    check("idle_normal", 32'(outs), 32'(NORMAL));

    @(negedge clk); setLoadUse(); #1;
    check("load_use", 32'(outs), 32'(STALL));

    @(negedge clk); ID_ReadRegUsed = 2'b00; #1;
    check("load_use_unused", 32'(outs), 32'(NORMAL));

    @(negedge clk); clearIn();
    EX_cntl_MemRead = 1'b1; ID_ReadRegUsed = 2'b01; #1;
    check("x0_no_match", 32'(outs), 32'(NORMAL));

    @(negedge clk); clearIn();
    ID_opcode = 7'b1100011; EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd5;
    ID_ReadRegNum = {5'd5, 5'd2}; ID_ReadRegUsed = 2'b11; #1;
    check("branch_ex", 32'(outs), 32'(STALL));

    @(negedge clk); clearIn();
    ID_opcode = 7'b1100111; MEM_cntl_MemRead = 1'b1; MEM_WriteRegNum = 5'd5;
    ID_ReadRegNum = {5'd0, 5'd5}; ID_ReadRegUsed = 2'b01; #1;
    check("jalr_mem", 32'(outs), 32'(STALL));

    @(negedge clk); clearIn();
    ID_opcode = 7'b1100111; EX_cntl_RegWrite = 1'b1; EX_WriteRegNum = 5'd5;
    MEM_cntl_MemRead = 1'b1; MEM_WriteRegNum = 5'd5;
    ID_ReadRegNum = {5'd5, 5'd3}; ID_ReadRegUsed = 2'b11; #1;
    check("jalr_src1_only", 32'(outs), 32'(NORMAL));
`ifdef HAZARD_PERF_CNT_EN
    check("perf_three", stall_cycles, 32'd3);
`else
    check("perf_off", stall_cycles, 32'd0);
`endif

    @(negedge clk); clearIn(); ID_redirect = 1'b1; #1;
    check("redirect", 32'(outs), 32'(REDIRECT));

    @(negedge clk); setLoadUse(); ID_redirect = 1'b1; #1;
    check("redirect_stall", 32'(outs), 32'(STALL));

    // Multicycle issue at T, hold T+1..T+3, free at T+4.
    @(negedge clk); clearIn(); ID_multicycle = 1'b1; #1;
    check("mc_issue", 32'(outs), 32'(NORMAL));
    check("mc_issue_lat1", 32'(outs1), 32'(NORMAL));
    @(negedge clk); clearIn(); #1;
    check("mc_t1", 32'(outs), 32'(HOLD));
    check("mc_t1_lat1", 32'(busy1), 32'd0);
    @(negedge clk); setLoadUse(); #1;
    check("mc_t2_hazard_masked", 32'(outs), 32'(HOLD));
    check("mc_t2_lat1_stall", 32'(outs1), 32'(STALL));
    @(negedge clk); clearIn(); #1;
    check("mc_t3", 32'(outs), 32'(HOLD));
    @(negedge clk); #1;
    check("mc_t4", 32'(outs), 32'(NORMAL));

    // Reset at T+2 aborts the hold.
    @(negedge clk); ID_multicycle = 1'b1; #1;
    check("abort_issue", 32'(outs), 32'(NORMAL));
    @(negedge clk); ID_multicycle = 1'b0; #1;
    check("abort_t1", 32'(outs), 32'(HOLD));
    @(negedge clk); reset = 1'b1; #1;
    check("abort_reset", 32'(outs), 32'(NORMAL));
    @(negedge clk); reset = 1'b0; #1;
    check("abort_after", 32'(outs), 32'(NORMAL));
    check("abort_cnt_clr", stall_cycles, 32'd0);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk); setLoadUse(); #1;
      check("perf_stall", 32'(outs), 32'(STALL));
    end
    @(negedge clk); clearIn(); #1;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_after_reset", stall_cycles, 32'd3);
`else
    check("perf_after_reset", stall_cycles, 32'd0);
`endif
    check("final_normal", 32'(outs), 32'(NORMAL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
